// File: rtl/header_filter.sv
// header_filter: latches dest/src/ethertype headers, makes an accept/drop
// decision at payload SOP and stores accepted beats in a first-word-fall-through
// FIFO with a ready/valid output. Keeps saturating packet statistics.
module header_filter #(
  parameter int DATA_W     = 64,
  parameter int BE_W       = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BEATS  = 8,
  parameter int CNT_W      = 32
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iPayload_valid,
  input  logic [DATA_W-1:0] iPayload,
  input  logic              iSop,
  input  logic              iEop,
  input  logic [BE_W-1:0]   iByte_enable,
  input  logic [47:0]       iHeader_A,
  input  logic              iHeader_A_valid,
  input  logic [47:0]       iHeader_B,
  input  logic              iHeader_B_valid,
  input  logic [15:0]       iHeader_C,
  input  logic              iHeader_C_valid,
  input  logic [47:0]       iMac_addr,
  input  logic [15:0]       iEthertype,
  input  logic              iEthertype_en,
  input  logic              iReady,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oSop,
  output logic              oEop,
  output logic [BE_W-1:0]   oByte_enable,
  output logic [CNT_W-1:0]  oAccept_cnt,
  output logic [CNT_W-1:0]  oDrop_cnt,
  output logic [CNT_W-1:0]  oTrunc_cnt,
  output logic [CNT_W-1:0]  oErr_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int EW = 2 + BE_W + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;

  state_t            r_state, w_state_n;
  logic [BW-1:0]     r_bcnt, w_bcnt_n;

  logic [47:0]       r_hdr_a, r_hdr_b;
  logic [15:0]       r_hdr_c;
  logic              r_seen_a, r_seen_b, r_seen_c;

  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_vis;
  logic              r_push_d;

  logic [CNT_W-1:0]  r_acc, r_drop, r_trunc, r_err;

  logic              w_sop_beat;
  logic [47:0]       w_hdr_a;
  logic [15:0]       w_hdr_c;
  logic              w_seen_all;
  logic              w_match;
  logic              w_space;
  logic              w_push, w_pop;
  logic [EW-1:0]     w_push_entry;
  logic [EW-1:0]     w_head;
  logic              w_inc_acc, w_inc_drop, w_inc_trunc, w_inc_err;
  logic              w_unused_hdr_b;

  assign w_sop_beat     = iPayload_valid & iSop;
  assign w_unused_hdr_b = ^r_hdr_b;

  // A strobe arriving together with SOP takes part in that SOP's decision.
  assign w_hdr_a    = iHeader_A_valid ? iHeader_A : r_hdr_a;
  assign w_hdr_c    = iHeader_C_valid ? iHeader_C : r_hdr_c;
  assign w_seen_all = (r_seen_a | iHeader_A_valid) &
                      (r_seen_b | iHeader_B_valid) &
                      (r_seen_c | iHeader_C_valid);
  assign w_match    = w_seen_all &
                      ((w_hdr_a == iMac_addr) | (w_hdr_a == '1)) &
                      (!iEthertype_en | (w_hdr_c == iEthertype));
  // Equivalent to FIFO_DEPTH - count >= MAX_BEATS, written without underflow.
  assign w_space    = (r_count <= CW'(FIFO_DEPTH - MAX_BEATS));

  // Header registers and seen flags; flags clear whenever a SOP is consumed.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_hdr_a  <= '0;
      r_hdr_b  <= '0;
      r_hdr_c  <= '0;
      r_seen_a <= 1'b0;
      r_seen_b <= 1'b0;
      r_seen_c <= 1'b0;
    end else begin
      if (iHeader_A_valid) r_hdr_a <= iHeader_A;
      if (iHeader_B_valid) r_hdr_b <= iHeader_B;
      if (iHeader_C_valid) r_hdr_c <= iHeader_C;
      if (w_sop_beat) begin
        r_seen_a <= 1'b0;
        r_seen_b <= 1'b0;
        r_seen_c <= 1'b0;
      end else begin
        if (iHeader_A_valid) r_seen_a <= 1'b1;
        if (iHeader_B_valid) r_seen_b <= 1'b1;
        if (iHeader_C_valid) r_seen_c <= 1'b1;
      end
    end
  end

  // FSM state and beat-count register.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_n;
      r_bcnt  <= w_bcnt_n;
    end
  end

  // Next-state, FIFO write request and counter increments.
  always_comb begin
    w_state_n    = r_state;
    w_bcnt_n     = r_bcnt;
    w_push       = 1'b0;
    w_push_entry = '0;
    w_inc_acc    = 1'b0;
    w_inc_drop   = 1'b0;
    w_inc_trunc  = 1'b0;
    w_inc_err    = 1'b0;
    if (iPayload_valid) begin
      unique case (r_state)
        S_IDLE, S_DROP: begin
          if (iSop) begin
            if (w_match && w_space) begin
              w_push       = 1'b1;
              w_push_entry = {1'b1, iEop, iByte_enable, iPayload};
              w_bcnt_n     = BW'(1);
              w_inc_acc    = 1'b1;
              w_state_n    = iEop ? S_IDLE : S_PASS;
            end else begin
              w_inc_drop   = 1'b1;
              w_state_n    = iEop ? S_IDLE : S_DROP;
            end
          end else if (r_state == S_DROP && iEop) begin
            w_state_n = S_IDLE;
          end
        end
        S_PASS: begin
          if (iSop) begin
            // Close the open packet with an empty terminator beat and discard
            // the packet that started unexpectedly.
            w_push       = 1'b1;
            w_push_entry = {1'b0, 1'b1, {BE_W{1'b0}}, {DATA_W{1'b0}}};
            w_inc_err    = 1'b1;
            w_bcnt_n     = '0;
            w_state_n    = iEop ? S_IDLE : S_DROP;
          end else begin
            w_push       = 1'b1;
            w_push_entry = {1'b0, iEop, iByte_enable, iPayload};
            w_bcnt_n     = r_bcnt + BW'(1);
            if (iEop) begin
              w_state_n = S_IDLE;
            end else if (r_bcnt + BW'(1) == BW'(MAX_BEATS)) begin
              w_push_entry[EW-2] = 1'b1;
              w_inc_trunc        = 1'b1;
              w_state_n          = S_DROP;
            end
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since visibility is tracked separately.
  always_ff @(posedge iClk) begin
    if (w_push) r_mem[r_wr] <= w_push_entry;
  end

  // FIFO pointers, occupancy and visible-entry count. A written entry becomes
  // visible one edge after its write; r_count includes not-yet-visible entries
  // so admission always reserves against the true occupancy.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_vis    <= '0;
      r_push_d <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      r_vis    <= r_vis + CW'(r_push_d) - CW'(w_pop);
      r_push_d <= w_push;
    end
  end

  assign oValid       = (r_vis != '0);
  assign w_pop        = oValid & iReady;
  assign w_head       = r_mem[r_rd];
  assign oSop         = oValid & w_head[EW-1];
  assign oEop         = oValid & w_head[EW-2];
  assign oByte_enable = oValid ? w_head[DATA_W +: BE_W] : '0;
  assign oData        = oValid ? w_head[DATA_W-1:0] : '0;

  // Saturating statistics counters, bumped on the decision cycle.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_acc   <= '0;
      r_drop  <= '0;
      r_trunc <= '0;
      r_err   <= '0;
    end else begin
      if (w_inc_acc   && r_acc   != '1) r_acc   <= r_acc   + CNT_W'(1);
      if (w_inc_drop  && r_drop  != '1) r_drop  <= r_drop  + CNT_W'(1);
      if (w_inc_trunc && r_trunc != '1) r_trunc <= r_trunc + CNT_W'(1);
      if (w_inc_err   && r_err   != '1) r_err   <= r_err   + CNT_W'(1);
    end
  end

  assign oAccept_cnt = r_acc;
  assign oDrop_cnt   = r_drop;
  assign oTrunc_cnt  = r_trunc;
  assign oErr_cnt    = r_err;

endmodule

// File: tb/tb_header_filter.sv
// Scoreboard bench for header_filter: stimulus pushes expected output beats,
// a negedge monitor pops and compares every beat the DUT hands over.
module tb_header_filter;

  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int CNT_W  = 32;
  localparam int MAXB   = 8;
  localparam int EW     = 2 + BE_W + DATA_W;

  localparam logic [47:0] MAC   = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] OTHER = 48'h112233445566;
  localparam logic [47:0] SRC   = 48'h020000000001;

  logic              iClk = 1'b0;
  logic              iReset;
  logic              iPayload_valid;
  logic [DATA_W-1:0] iPayload;
  logic              iSop, iEop;
  logic [BE_W-1:0]   iByte_enable;
  logic [47:0]       iHeader_A, iHeader_B;
  logic [15:0]       iHeader_C;
  logic              iHeader_A_valid, iHeader_B_valid, iHeader_C_valid;
  logic [47:0]       iMac_addr;
  logic [15:0]       iEthertype;
  logic              iEthertype_en;
  logic              iReady;
  logic              oValid;
  logic [DATA_W-1:0] oData;
  logic              oSop, oEop;
  logic [BE_W-1:0]   oByte_enable;
  logic [CNT_W-1:0]  oAccept_cnt, oDrop_cnt, oTrunc_cnt, oErr_cnt;

  header_filter #(
    .DATA_W(DATA_W), .BE_W(BE_W), .FIFO_DEPTH(16), .MAX_BEATS(MAXB), .CNT_W(CNT_W)
  ) dut (
    .iClk(iClk), .iReset(iReset),
    .iPayload_valid(iPayload_valid), .iPayload(iPayload),
    .iSop(iSop), .iEop(iEop), .iByte_enable(iByte_enable),
    .iHeader_A(iHeader_A), .iHeader_A_valid(iHeader_A_valid),
    .iHeader_B(iHeader_B), .iHeader_B_valid(iHeader_B_valid),
    .iHeader_C(iHeader_C), .iHeader_C_valid(iHeader_C_valid),
    .iMac_addr(iMac_addr), .iEthertype(iEthertype), .iEthertype_en(iEthertype_en),
    .iReady(iReady),
    .oValid(oValid), .oData(oData), .oSop(oSop), .oEop(oEop),
    .oByte_enable(oByte_enable),
    .oAccept_cnt(oAccept_cnt), .oDrop_cnt(oDrop_cnt),
    .oTrunc_cnt(oTrunc_cnt), .oErr_cnt(oErr_cnt)
  );

  always #5 iClk = ~iClk;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each handed-over beat; idle outputs must read as zero.
  always @(negedge iClk) begin
    if (!iReset) begin
      if (oValid && iReady) begin
        logic [EW-1:0] act, exp;
        act = {oSop, oEop, oByte_enable, oData};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_beat: unexpected beat %0h, none expected", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            n_err++;
            $display("FAIL out_beat: got %0h expected %0h", act, exp);
          end
        end
      end else if (!oValid) begin
        n_cmp++;
        if (oData !== '0 || oSop !== 1'b0 || oEop !== 1'b0 || oByte_enable !== '0) begin
          n_err++;
          $display("FAIL idle_zero: got data=%0h sop=%0b eop=%0b be=%0h required all 0",
                   oData, oSop, oEop, oByte_enable);
        end
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic send_hdr(input logic [47:0] a, input logic [15:0] c);
    iHeader_A = a; iHeader_B = SRC; iHeader_C = c;
    iHeader_A_valid = 1'b1; iHeader_B_valid = 1'b1; iHeader_C_valid = 1'b1;
    tick();
    iHeader_A_valid = 1'b0; iHeader_B_valid = 1'b0; iHeader_C_valid = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] be, input logic sop, input logic eop);
    iPayload_valid = 1'b1; iPayload = d; iByte_enable = be; iSop = sop; iEop = eop;
    tick();
    iPayload_valid = 1'b0; iSop = 1'b0; iEop = 1'b0; iByte_enable = '0; iPayload = '0;
  endtask

  // n-beat packet; when acc is set the expected output (truncated to MAXB
  // beats, last one forced eop) is queued.
  task automatic send_pkt(input int id, input int n, input logic [7:0] last_be, input bit acc);
    for (int i = 0; i < n; i++) begin
      logic [63:0] d;
      logic [7:0]  be;
      logic        sop, eop;
      d   = {32'(id), 32'(i)};
      be  = (i == n - 1) ? last_be : 8'hFF;
      sop = (i == 0);
      eop = (i == n - 1);
      if (acc && i < MAXB)
        exp_q.push_back({sop, eop | (i == MAXB - 1 && n > MAXB), be, d});
      beat(d, be, sop, eop);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && !oValid) break;
      tick();
    end
    repeat (3) tick();
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_ovalid"}, 64'(oValid), 64'd0);
  endtask

  task automatic chk_cnt(input string name, input int a, input int d, input int t, input int e);
    chk({name, "_accept"}, 64'(oAccept_cnt), 64'(a));
    chk({name, "_drop"},   64'(oDrop_cnt),   64'(d));
    chk({name, "_trunc"},  64'(oTrunc_cnt),  64'(t));
    chk({name, "_err"},    64'(oErr_cnt),    64'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    iReset = 1'b1; iPayload_valid = 1'b0; iPayload = '0; iSop = 1'b0; iEop = 1'b0;
    iByte_enable = '0; iHeader_A = '0; iHeader_B = '0; iHeader_C = '0;
    iHeader_A_valid = 1'b0; iHeader_B_valid = 1'b0; iHeader_C_valid = 1'b0;
    iMac_addr = MAC; iEthertype = 16'h0800; iEthertype_en = 1'b0; iReady = 1'b1;
    repeat (3) tick();
    chk("rst_ovalid", 64'(oValid), 64'd0);
    chk("rst_odata", oData, 64'd0);
    chk_cnt("rst", 0, 0, 0, 0);
    iReset = 1'b0;
    tick();

    // 1: unicast match, 3 beats, last be 0F
    send_hdr(MAC, 16'h0800);
    send_pkt(1, 3, 8'h0F, 1);
    drain("t1");
    chk_cnt("t1", 1, 0, 0, 0);

    // 2: dest mismatch dropped, then broadcast accepted
    send_hdr(OTHER, 16'h0800);
    send_pkt(2, 3, 8'hFF, 0);
    drain("t2a");
    chk_cnt("t2a", 1, 1, 0, 0);
    send_hdr(BCAST, 16'h0800);
    send_pkt(3, 2, 8'h03, 1);
    drain("t2b");
    chk_cnt("t2b", 2, 1, 0, 0);

    // 3: ethertype enforcement
    iEthertype_en = 1'b1;
    send_hdr(MAC, 16'h86DD);
    send_pkt(4, 3, 8'hFF, 0);
    drain("t3a");
    chk_cnt("t3a", 2, 2, 0, 0);
    send_hdr(MAC, 16'h0800);
    send_pkt(5, 4, 8'h01, 1);
    drain("t3b");
    chk_cnt("t3b", 3, 2, 0, 0);
    iEthertype_en = 1'b0;

    // 4: backpressure fills the FIFO, third packet rejected for space
    iReady = 1'b0;
    send_hdr(MAC, 16'h0800);
    send_pkt(6, 8, 8'hFF, 1);
    send_hdr(MAC, 16'h0800);
    send_pkt(7, 8, 8'h7F, 1);
    send_hdr(MAC, 16'h0800);
    send_pkt(8, 3, 8'hFF, 0);
    repeat (2) tick();
    chk("t4_held_ovalid", 64'(oValid), 64'd1);
    chk("t4_queued", 64'(exp_q.size()), 64'd16);
    chk_cnt("t4", 5, 3, 0, 0);
    iReady = 1'b1;
    drain("t4");

    // 5: 10-beat packet truncated at 8, then a normal packet
    send_hdr(MAC, 16'h0800);
    send_pkt(9, 10, 8'h0F, 1);
    drain("t5a");
    chk_cnt("t5a", 6, 3, 1, 0);
    send_hdr(MAC, 16'h0800);
    send_pkt(10, 2, 8'h3F, 1);
    drain("t5b");
    chk_cnt("t5b", 7, 3, 1, 0);

    // 6: SOP in the middle of an accepted packet
    send_hdr(MAC, 16'h0800);
    exp_q.push_back({1'b1, 1'b0, 8'hFF, 64'h0000003C_00000000});
    beat(64'h0000003C_00000000, 8'hFF, 1'b1, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'hFF, 64'h0000003C_00000001});
    beat(64'h0000003C_00000001, 8'hFF, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b1, 8'h00, 64'h0});
    beat(64'h0000003D_00000000, 8'hFF, 1'b1, 1'b0);
    beat(64'h0000003D_00000001, 8'hFF, 1'b0, 1'b0);
    beat(64'h0000003D_00000002, 8'h0F, 1'b0, 1'b1);
    drain("t6a");
    chk("t6a_err", 64'(oErr_cnt), 64'd1);
    chk("t6a_accept", 64'(oAccept_cnt), 64'd8);
    send_hdr(MAC, 16'h0800);
    send_pkt(11, 2, 8'hFF, 1);
    drain("t6b");
    chk("t6b_accept", 64'(oAccept_cnt), 64'd9);

    // Reset in the middle of a packet held in the FIFO
    iReady = 1'b0;
    send_hdr(MAC, 16'h0800);
    beat(64'h0000000C_00000000, 8'hFF, 1'b1, 1'b0);
    beat(64'h0000000C_00000001, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("t6c_held_ovalid", 64'(oValid), 64'd1);
    iReset = 1'b1;
    tick();
    tick();
    exp_q.delete();
    chk("t6c_rst_ovalid", 64'(oValid), 64'd0);
    chk_cnt("t6c_rst", 0, 0, 0, 0);
    iReset = 1'b0;
    iReady = 1'b1;
    beat(64'h0000000C_00000002, 8'hFF, 1'b0, 1'b1);
    send_hdr(MAC, 16'h0800);
    send_pkt(13, 3, 8'h1F, 1);
    drain("t6d");
    chk_cnt("t6d", 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
